// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB and commit signals of the reorder buffer.
// The slave side is the buffer; the master side drives dispatch and the CDB.
interface reorder_buffer_if #(
    parameter int D_WIDTH = 31,
    parameter int A_WIDTH = 4,
    parameter int R_WIDTH = 2
);
    logic               allocate;
    logic [A_WIDTH:0]   alloc_dest;
    logic               alloc_writes;
    logic               alloc_ready;
    logic [R_WIDTH:0]   alloc_tag;
    logic               cdb_valid;
    logic [R_WIDTH:0]   cdb_tag;
    logic [D_WIDTH:0]   cdb_data;
    logic               flush;
    logic               regWrite;
    logic [A_WIDTH:0]   wraddress;
    logic [D_WIDTH:0]   wdata;
    logic               commit_valid;
    logic [R_WIDTH:0]   commit_tag;
    logic [R_WIDTH+1:0] count;

    modport master (
        output allocate, alloc_dest, alloc_writes,
        output cdb_valid, cdb_tag, cdb_data, flush,
        input  alloc_ready, alloc_tag,
        input  regWrite, wraddress, wdata,
        input  commit_valid, commit_tag, count
    );

    modport slave (
        input  allocate, alloc_dest, alloc_writes,
        input  cdb_valid, cdb_tag, cdb_data, flush,
        output alloc_ready, alloc_tag,
        output regWrite, wraddress, wdata,
        output commit_valid, commit_tag, count
    );
endinterface

// File: rtl/reorder_buffer.sv
// Eight-entry reorder buffer: in-order allocate, out-of-order CDB capture,
// in-order single-issue commit into the register file write port.
module reorder_buffer #(
    parameter int D_WIDTH = 31,
    parameter int A_WIDTH = 4,
    parameter int R_WIDTH = 2
) (
    input logic             clk,
    input logic             reset,
    reorder_buffer_if.slave rob
);
    localparam int DEPTH = 2 ** (R_WIDTH + 1);

    typedef struct packed {
        logic             busy;
        logic             ready;
        logic             writes;
        logic [A_WIDTH:0] dest;
        logic [D_WIDTH:0] data;
    } entry_t;

    entry_t             ent [DEPTH];
    logic [R_WIDTH:0]   head;
    logic [R_WIDTH:0]   tail;
    logic [R_WIDTH+1:0] cnt;
    logic               do_alloc;
    logic               do_commit;
    logic               do_cdb;

    // Occupancy below 8 is exactly "top count bit clear".
    assign rob.alloc_ready = ~cnt[R_WIDTH+1];
    assign rob.alloc_tag   = tail;
    assign rob.count       = cnt;

    assign do_alloc  = rob.allocate & rob.alloc_ready;
    assign do_commit = ent[head].busy & ent[head].ready;
    assign do_cdb    = rob.cdb_valid & ent[rob.cdb_tag].busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head             <= '0;
            tail             <= '0;
            cnt              <= '0;
            rob.regWrite     <= 1'b0;
            rob.commit_valid <= 1'b0;
            rob.commit_tag   <= '0;
            rob.wraddress    <= '0;
            rob.wdata        <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else if (rob.flush) begin
            head             <= '0;
            tail             <= '0;
            cnt              <= '0;
            rob.regWrite     <= 1'b0;
            rob.commit_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].busy  <= 1'b0;
                ent[i].ready <= 1'b0;
            end
        end else begin
            if (do_alloc) begin
                ent[tail].busy   <= 1'b1;
                ent[tail].ready  <= 1'b0;
                ent[tail].writes <= rob.alloc_writes;
                ent[tail].dest   <= rob.alloc_dest;
                tail             <= tail + 1'b1;
            end
            if (do_cdb) begin
                ent[rob.cdb_tag].data  <= rob.cdb_data;
                ent[rob.cdb_tag].ready <= 1'b1;
            end
            rob.commit_valid <= do_commit;
            rob.regWrite     <= do_commit & ent[head].writes
                                & (ent[head].dest != '0);
            if (do_commit) begin
                ent[head].busy <= 1'b0;
                head           <= head + 1'b1;
                rob.commit_tag <= head;
                rob.wraddress  <= ent[head].dest;
                rob.wdata      <= ent[head].data;
            end
            unique case ({do_alloc, do_commit})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order commit stage directly upstream of `register_file`. Holds up to 8 in-flight instructions in program order and captures their results from the common data bus (CDB). Retires completed instructions from the head, at most one per cycle. Drives the register file write port (`regWrite`, `wraddress`, `wdata`) so that architectural state updates strictly in program order.

## Interface
- D_WIDTH, 31, MSB index of data path (32-bit values)
- A_WIDTH, 4, MSB index of architectural register address (32 registers)
- R_WIDTH, 2, MSB index of ROB tag (8 entries, depth = 2^(R_WIDTH+1))

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- allocate  in  1  dispatch requests an entry this cycle
- alloc_dest  in  A_WIDTH+1  destination register of dispatched instruction
- alloc_writes  in  1  instruction writes a destination register
- alloc_ready  out  1  combinational; 1 when count < 8
- alloc_tag  out  R_WIDTH+1  combinational; tag of entry granted (= tail pointer)
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  R_WIDTH+1  ROB tag of broadcast result
- cdb_data  in  D_WIDTH+1  result value
- flush  in  1  synchronous squash of all entries
- regWrite  out  1  registered; register-file write enable
- wraddress  out  A_WIDTH+1  registered; register-file write address
- wdata  out  D_WIDTH+1  registered; register-file write data
- commit_valid  out  1  registered; one instruction retired (with or without write)
- commit_tag  out  R_WIDTH+1  registered; tag of retired instruction
- count  out  R_WIDTH+2  registered; current occupancy, 0..8

## Operation
- Storage: circular array of 8 entries, fields busy, ready, writes, dest, data. Pointers head, tail (R_WIDTH+1 bits, wrap 7->0) plus count.
- Allocate: fires when allocate && alloc_ready. Writes entry[tail] with busy=1, ready=0, writes=alloc_writes, dest=alloc_dest. Tail increments and wraps. allocate while full is ignored; no state change.
- Result capture: cdb_valid with entry[cdb_tag].busy=1 sets data=cdb_data, ready=1. cdb_valid to a non-busy entry is ignored. A duplicate broadcast to a ready entry overwrites data.
- Commit: fires when entry[head].busy && entry[head].ready, evaluated on registered state. Clears busy and advances head. At the next edge it registers commit_valid=1, commit_tag=head, wraddress=dest, wdata=data, regWrite = writes && (dest != 0). Writes to x0 retire without asserting regWrite.
- With no commit, regWrite=0 and commit_valid=0 next cycle; wraddress/wdata hold their last values.
- Count: +1 on allocate only, -1 on commit only, unchanged on both or neither.
- Flush: has priority over allocate, CDB capture and commit in the same cycle. At the edge it clears all busy/ready bits and sets head=tail=0, count=0, regWrite=0, commit_valid=0.
- Reset (async, any time, including mid-commit): head=tail=count=0, all busy/ready=0. Outputs regWrite=0, commit_valid=0, commit_tag=0, wraddress=0, wdata=0, alloc_ready=1, alloc_tag=0.

## Timing
- Allocate in cycle N: entry is visible as busy from edge N.
- CDB capture in cycle N: ready is set at edge N. Earliest commit decision is cycle N+1, so regWrite is high in cycle N+2 (after edge N+1). No CDB-to-commit bypass.
- Throughput: one allocate, one CDB capture and one commit per cycle.
- Full (count=8): alloc_ready=0 even if a commit fires the same cycle; the freed slot becomes available the next cycle.
- Empty (count=0): no commit; a CDB broadcast naming any tag is ignored.
- Allocate and commit on the same entry index in the same cycle is only possible when count=8, which is blocked; no conflict arises.
- regWrite is a single-cycle pulse per retired writing instruction. Back-to-back commits produce consecutive pulses.

## Test plan
- Reset mid-operation with 3 entries live -> all outputs at reset values immediately, count=0, alloc_tag=0, alloc_ready=1.
- Allocate tags 0,1,2 (dests x4, x9, x3). CDB returns tag 2=60, tag 0=60, tag 1=80, one per cycle -> commits in order x4=60, x9=80, x3=60, one regWrite pulse per cycle, no pulse before tag 0 is ready.
- Allocate 8 entries -> alloc_ready=0, count=8. A 9th allocate is ignored. Commit one -> alloc_ready=1 next cycle, tail wraps to 0, and the new allocation gets alloc_tag=0.
- Allocate with dest x0 and alloc_writes=1, CDB data 9 -> commit_valid=1, regWrite=0.
- Three entries live, one ready; assert flush together with allocate and cdb_valid -> count=0, no commit, no regWrite; the next allocate gets tag 0.
- CDB tag 5 while only tags 0..1 are busy -> ignored; entry 5 stays not busy, no commit is generated.
